oled_text_ctrl: RTL and testbench
=================================

Name: oled_text_ctrl

Overview:
- Character-level controller that sequences the OLED 6-column glyph writer.
- Buffers incoming ASCII codes in a small FIFO, fetches each 48-bit glyph from an external font ROM, and computes page/column positions.
- Issues one write transaction per character and maintains a text cursor with line wrap.
- Sits between the text source (UART/keypad logic) and the glyph writer; the writer in turn drives the SPI sender.

Parameters:
- COLS, 21, characters per line.
- ROWS, 8, pages (lines) on the panel.
- CHAR_W, 6, pixel columns per glyph.
- X_OFFSET, 0, column offset added to every x position (panel RAM offset).
- FIFO_DEPTH, 4, character buffer depth (power of two).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- char_valid  in  1  character offered.
- char_data  in  8  ASCII code.
- char_ready  out  1  FIFO not full; a character is accepted when valid && ready.
- font_addr  out  8  font ROM address (registered).
- font_data  in  48  glyph columns, MSB byte = leftmost column; ROM has 1-cycle read latency.
- wr_start  out  1  one-cycle start pulse to the glyph writer.
- wr_data  out  48  glyph to write.
- wr_pos_x  out  8  start column.
- wr_pos_y  out  8  page number.
- wr_done  in  1  writer completion pulse (single cycle).
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- cursor_col  out  5  current column index.
- cursor_row  out  3  current row index.

Behaviour:
- Reset: all outputs 0; char_ready = 1 after reset; FIFO flushed; cursor at (0,0); FSM in IDLE. Reset mid-transaction aborts immediately with no completion.
- FIFO:
  - char_ready = !full, derived from the registered count.
  - A push while full cannot occur; a pop only occurs while non-empty.
  - Simultaneous push and pop keeps the count unchanged.
- FSM states: IDLE, FETCH, LATCH, START, WAIT, ADVANCE (plus CLEAR, optional).
- IDLE:
  - FIFO non-empty: pop the head.
    - 0x0A (newline): col := 0, row := (row+1) mod ROWS; stay in IDLE.
    - 0x0D (carriage return): col := 0; stay in IDLE.
    - 0x0C: see Optional Feature.
    - Any other code: font_addr := code, go to FETCH.
- FETCH: wait one cycle for the ROM; go to LATCH.
- LATCH: wr_data := font_data; wr_pos_x := X_OFFSET + col*CHAR_W (8-bit, truncating); wr_pos_y := row. Go to START.
- START: wr_start = 1 for exactly this cycle; go to WAIT.
- WAIT: hold wr_data and wr_pos_* stable until wr_done = 1; then go to ADVANCE. No timeout.
- ADVANCE:
  - If col == COLS-1: col := 0 and row := (row+1) mod ROWS (row ROWS-1 wraps to row 0).
  - Otherwise col := col+1.
  - Return to IDLE.
- Latency: wr_start is high in the third cycle after the pop edge. Minimum per-character overhead outside WAIT is 5 cycles.
- wr_data, wr_pos_x and wr_pos_y are registered and change only in LATCH (and in CLEAR when the feature is compiled in).
- wr_done outside WAIT is ignored.

Optional Feature:
- Macro: OLED_CLEAR_CMD_EN.
- Defined: code 0x0C enters CLEAR. The block writes 48'h0 to every position in row-major order from (0,0) through (ROWS-1, COLS-1), one START/WAIT handshake per position (ROWS*COLS writes; 168 by default). It then sets the cursor to (0,0) and returns to IDLE. FIFO pushes remain accepted during the clear.
- Undefined: 0x0C is popped and discarded; no write is issued and the cursor is unchanged.

Decomposition:
- Package oled_pkg:
  - Control-code constants: CHAR_LF = 8'h0A, CHAR_CR = 8'h0D, CHAR_FF = 8'h0C.
  - FSM state encoding.
  - CHAR_W default.
- One sub-module: oled_char_fifo (synchronous FIFO with count; full/empty flags; FIFO_DEPTH parameter).

Test Plan:
- Push 'A' (0x41); the ROM returns 48'h7E_11_11_11_7E_00. Expected: font_addr = 0x41; wr_start pulses once, 3 cycles after the pop; wr_data = that glyph; wr_pos_x = 0; wr_pos_y = 0; after wr_done, cursor = (1,0).
- Push 21 printable characters. Expected: the 21st writes at x = 120; the cursor then wraps to (0,1); the 22nd writes at x = 0, y = 1.
- Cursor at (5,7), push 0x0A then 'B'. Expected: the newline issues no wr_start; 'B' writes at x = 0, y = 0.
- Hold char_valid high with wr_done delayed 200 cycles. Expected: char_ready drops after 4 entries beyond the in-flight character; no character is lost or duplicated; write order matches push order.
- Assert reset during WAIT. Expected: all outputs 0, cursor (0,0), FIFO empty; a late wr_done after reset is ignored.
- With OLED_CLEAR_CMD_EN, push 0x0C. Expected: 168 wr_start pulses with wr_data = 0 (last at x = 120, y = 7), then cursor (0,0). Without the macro: no wr_start pulse.

Source files
------------

// File: rtl/oled_pkg.sv
// oled_pkg: control codes, glyph width and FSM encoding
// shared by the OLED text controller files.
package oled_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  localparam int CHAR_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_WAIT,
    ST_ADVANCE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/oled_char_fifo.sv
// oled_char_fifo: small synchronous character FIFO with
// a registered occupancy count driving full/empty.
module oled_char_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P    = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = cnt_q == FULL_CNT;
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wp_q <= wp_q + ONE_P;
      if (do_pop)  rp_q <= rp_q + ONE_P;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/oled_text_ctrl.sv
// oled_text_ctrl: buffers ASCII codes, fetches glyphs and drives the glyph
// writer with a wrapping cursor. OLED_CLEAR_CMD_EN enables the 0x0C clear.
module oled_text_ctrl
  import oled_pkg::*;
#(
  parameter int COLS       = 21,
  parameter int ROWS       = 8,
  parameter int CHAR_W     = CHAR_W_DEF,
  parameter int X_OFFSET   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [7:0]  font_addr,
  input  logic [47:0] font_data,
  output logic        wr_start,
  output logic [47:0] wr_data,
  output logic [7:0]  wr_pos_x,
  output logic [7:0]  wr_pos_y,
  input  logic        wr_done,
  output logic        busy,
  output logic [4:0]  cursor_col,
  output logic [2:0]  cursor_row
);

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [47:0] data_q, data_d;
  logic [7:0]  px_q, px_d;
  logic [7:0]  py_q, py_d;
  logic [4:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic        clr_q, clr_d;

  logic        pop, full, empty;
  logic [7:0]  head;
  logic        last_col, last_row;
  logic [2:0]  row_nx;
  logic [7:0]  pos_x;

  oled_char_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (8)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (char_valid),
    .din_i  (char_data),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign last_col = col_q == 5'(COLS - 1);
  assign last_row = row_q == 3'(ROWS - 1);
  assign row_nx   = last_row ? 3'd0 : row_q + 3'd1;
  assign pos_x    = 8'(X_OFFSET + CHAR_W * int'(col_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      px_q    <= px_d;
      py_q    <= py_d;
      col_q   <= col_d;
      row_q   <= row_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    px_d    = px_q;
    py_d    = py_q;
    col_d   = col_q;
    row_d   = row_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          unique case (1'b1)
            head == CHAR_LF: begin
              col_d = '0;
              row_d = row_nx;
            end
            head == CHAR_CR: col_d = '0;
            head == CHAR_FF: begin
`ifdef OLED_CLEAR_CMD_EN
              col_d   = '0;
              row_d   = '0;
              clr_d   = 1'b1;
              state_d = ST_CLEAR;
`endif
            end
            default: begin
              addr_d  = head;
              state_d = ST_FETCH;
            end
          endcase
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        data_d  = font_data;
        px_d    = pos_x;
        py_d    = {5'b0, row_q};
        state_d = ST_START;
      end
      ST_CLEAR: begin
        data_d  = '0;
        px_d    = pos_x;
        py_d    = {5'b0, row_q};
        state_d = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: if (wr_done) state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        if (last_col) begin
          col_d = '0;
          row_d = row_nx;
        end else begin
          col_d = col_q + 5'd1;
        end
        state_d = ST_IDLE;
        // The clear walks the cursor itself; wrapping past the
        // last cell lands it back on (0,0).
        if (clr_q) begin
          if (last_col && last_row) clr_d   = 1'b0;
          else                      state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = (state_q == ST_IDLE) && !empty;
    wr_start = state_q == ST_START;
    busy     = (state_q != ST_IDLE) || !empty;
  end

  assign char_ready = !full;
  assign font_addr  = addr_q;
  assign wr_data    = data_q;
  assign wr_pos_x   = px_q;
  assign wr_pos_y   = py_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_oled_text_ctrl.sv
// tb_oled_text_ctrl: directed bench with a font ROM model
// and a glyph-writer responder recording every write.
`timescale 1ns/1ps
module tb_oled_text_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic [7:0]  font_addr;
  logic [47:0] font_data = '0;
  logic        wr_start;
  logic [47:0] wr_data;
  logic [7:0]  wr_pos_x, wr_pos_y;
  logic        wr_done = 1'b0;
  logic        busy;
  logic [4:0]  cursor_col;
  logic [2:0]  cursor_row;

  int n_chk = 0;
  int n_fail = 0;
  int done_dly = 1;
  int done_cnt = 0;
  bit auto_done = 1'b1;
  bit force_done = 1'b0;

  logic [47:0] q_data[$];
  logic [7:0]  q_x[$];
  logic [7:0]  q_y[$];

  oled_text_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .font_addr (font_addr),
    .font_data (font_data),
    .wr_start  (wr_start),
    .wr_data   (wr_data),
    .wr_pos_x  (wr_pos_x),
    .wr_pos_y  (wr_pos_y),
    .wr_done   (wr_done),
    .busy      (busy),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] glyph(input logic [7:0] a);
    if (a == 8'h41) return 48'h7E_11_11_11_7E_00;
    return {a, ~a, a ^ 8'h5A, 8'hC3, a, 8'h81};
  endfunction

  always @(posedge clk) font_data <= glyph(font_addr);

  always @(negedge clk) begin
    wr_done = 1'b0;
    if (reset) done_cnt = 0;
    else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) wr_done = 1'b1;
    end
    if (force_done) wr_done = 1'b1;
    if (wr_start) begin
      q_data.push_back(wr_data);
      q_x.push_back(wr_pos_x);
      q_y.push_back(wr_pos_y);
      if (auto_done) done_cnt = done_dly;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    char_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_data.delete();
    q_x.delete();
    q_y.delete();
    done_dly = 1;
    auto_done = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, output bit ok);
    int n = 0;
    char_data = d;
    char_valid = 1'b1;
    while (!char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = char_ready;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if (wr_start !== 1'b0 || wr_data !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_wr: start=%b data=%h want 0", wr_start, wr_data);
    end
    n_chk++;
    if (wr_pos_x !== 8'h0 || wr_pos_y !== 8'h0 || font_addr !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_pos: x=%h y=%h addr=%h want 0",
               wr_pos_x, wr_pos_y, font_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (char_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ready=%b busy=%b want 1/0", char_ready, busy);
    end
    n_chk++;
    if (cursor_col !== 5'd0 || cursor_row !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)",
               cursor_col, cursor_row);
    end
  endtask

  task automatic test_single_char();
    int n = 0;
    bit ok;
    do_reset();
    char_data = 8'h41;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    while (!wr_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles want 3", n);
    end
    n_chk++;
    if (font_addr !== 8'h41) begin
      n_fail++;
      $display("FAIL single_addr: got %h want 41", font_addr);
    end
    n_chk++;
    if (wr_data !== 48'h7E1111117E00) begin
      n_fail++;
      $display("FAIL single_data: got %h want 7e1111117e00", wr_data);
    end
    n_chk++;
    if (wr_pos_x !== 8'd0 || wr_pos_y !== 8'd0) begin
      n_fail++;
      $display("FAIL single_pos: got (%0d,%0d) want (0,0)", wr_pos_x, wr_pos_y);
    end
    wait_idle(50, ok);
    n_chk++;
    if (!ok || q_x.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: idle=%b writes=%0d want 1/1", ok, q_x.size());
    end
    n_chk++;
    if (cursor_col !== 5'd1 || cursor_row !== 3'd0) begin
      n_fail++;
      $display("FAIL single_cursor: got (%0d,%0d) want (1,0)",
               cursor_col, cursor_row);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok = 1'b1;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      send(8'(8'h30 + i), ok);
      all_ok &= ok;
    end
    char_valid = 1'b0;
    wait_idle(1000, ok);
    all_ok &= ok;
    n_chk++;
    if (!all_ok || q_x.size() != 22) begin
      n_fail++;
      $display("FAIL wrap_count: ok=%b writes=%0d want 1/22", all_ok, q_x.size());
    end
    n_chk++;
    if (q_x[20] !== 8'd120 || q_y[20] !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_21st: got (%0d,%0d) want (120,0)", q_x[20], q_y[20]);
    end
    n_chk++;
    if (q_x[21] !== 8'd0 || q_y[21] !== 8'd1 || q_data[21] !== glyph(8'h45)) begin
      n_fail++;
      $display("FAIL wrap_22nd: got (%0d,%0d) %h want (0,1) %h",
               q_x[21], q_y[21], q_data[21], glyph(8'h45));
    end
    n_chk++;
    if (cursor_col !== 5'd1 || cursor_row !== 3'd1) begin
      n_fail++;
      $display("FAIL wrap_cursor: got (%0d,%0d) want (1,1)",
               cursor_col, cursor_row);
    end
  endtask

  task automatic test_newline();
    bit ok;
    int base;
    do_reset();
    for (int i = 0; i < 7; i++) send(8'h0A, ok);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i), ok);
    char_valid = 1'b0;
    wait_idle(500, ok);
    n_chk++;
    if (cursor_col !== 5'd5 || cursor_row !== 3'd7) begin
      n_fail++;
      $display("FAIL nl_setup: got (%0d,%0d) want (5,7)", cursor_col, cursor_row);
    end
    base = q_x.size();
    send(8'h0A, ok);
    send(8'h42, ok);
    char_valid = 1'b0;
    wait_idle(100, ok);
    n_chk++;
    if (q_x.size() != base + 1) begin
      n_fail++;
      $display("FAIL nl_writes: got %0d want %0d", q_x.size(), base + 1);
    end
    n_chk++;
    if (q_x[base] !== 8'd0 || q_y[base] !== 8'd0 || q_data[base] !== glyph(8'h42)) begin
      n_fail++;
      $display("FAIL nl_b_pos: got (%0d,%0d) %h want (0,0) %h",
               q_x[base], q_y[base], q_data[base], glyph(8'h42));
    end
    send(8'h0D, ok);
    char_valid = 1'b0;
    wait_idle(100, ok);
    n_chk++;
    if (cursor_col !== 5'd0 || cursor_row !== 3'd0 || q_x.size() != base + 1) begin
      n_fail++;
      $display("FAIL cr_cursor: got (%0d,%0d) writes=%0d want (0,0) %0d",
               cursor_col, cursor_row, q_x.size(), base + 1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    done_dly = 200;
    for (int i = 0; i < 5; i++) send(8'(8'h50 + i), ok);
    n_chk++;
    if (char_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: ready=%b busy=%b want 0/1", char_ready, busy);
    end
    send(8'h55, ok);
    char_valid = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_accept: 6th char accepted=%b want 1", ok);
    end
    wait_idle(3000, ok);
    n_chk++;
    if (!ok || q_x.size() != 6) begin
      n_fail++;
      $display("FAIL bp_count: idle=%b writes=%0d want 1/6", ok, q_x.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (q_data[i] !== glyph(8'(8'h50 + i)) || q_x[i] !== 8'(6 * i)) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h x=%0d want %h x=%0d",
                 i, q_data[i], q_x[i], glyph(8'(8'h50 + i)), 6 * i);
      end
    end
  endtask

  task automatic test_reset_wait();
    bit ok;
    int n = 0;
    do_reset();
    auto_done = 1'b0;
    send(8'h41, ok);
    send(8'h42, ok);
    send(8'h43, ok);
    char_valid = 1'b0;
    while (!wr_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (wr_start !== 1'b0 || wr_data !== 48'h0 || font_addr !== 8'h0) begin
      n_fail++;
      $display("FAIL rw_out: start=%b data=%h addr=%h want 0",
               wr_start, wr_data, font_addr);
    end
    n_chk++;
    if (wr_pos_x !== 8'h0 || wr_pos_y !== 8'h0 || busy !== 1'b0 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_flags: x=%h y=%h busy=%b ready=%b want 0/0/0/1",
               wr_pos_x, wr_pos_y, busy, char_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 force_done = 1'b1;
    @(negedge clk);
    #1 force_done = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++;
    if (q_x.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_after: writes=%0d busy=%b want 1/0", q_x.size(), busy);
    end
    n_chk++;
    if (cursor_col !== 5'd0 || cursor_row !== 3'd0) begin
      n_fail++;
      $display("FAIL rw_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_clear();
    bit ok;
    int nz = 0;
    do_reset();
    send(8'h41, ok);
    send(8'h0C, ok);
    char_valid = 1'b0;
    wait_idle(3000, ok);
`ifdef OLED_CLEAR_CMD_EN
    for (int i = 1; i < q_data.size(); i++) if (q_data[i] != 48'h0) nz++;
    n_chk++;
    if (!ok || q_x.size() != 169 || nz != 0) begin
      n_fail++;
      $display("FAIL clr_count: idle=%b writes=%0d nonzero=%0d want 1/169/0",
               ok, q_x.size(), nz);
    end
    n_chk++;
    if (q_x[168] !== 8'd120 || q_y[168] !== 8'd7) begin
      n_fail++;
      $display("FAIL clr_last: got (%0d,%0d) want (120,7)", q_x[168], q_y[168]);
    end
    n_chk++;
    if (cursor_col !== 5'd0 || cursor_row !== 3'd0) begin
      n_fail++;
      $display("FAIL clr_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row);
    end
`else
    n_chk++;
    if (!ok || q_x.size() != 1 || nz != 0) begin
      n_fail++;
      $display("FAIL ff_writes: idle=%b writes=%0d want 1/1", ok, q_x.size());
    end
    n_chk++;
    if (cursor_col !== 5'd1 || cursor_row !== 3'd0) begin
      n_fail++;
      $display("FAIL ff_cursor: got (%0d,%0d) want (1,0)", cursor_col, cursor_row);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_wrap();
    test_newline();
    test_backpressure();
    test_reset_wait();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
